// File: rtl/sad_pkg.sv
// Shared types and helpers for the lane-parallel SAD/SSD block accumulator.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_SAD = 1'b0,
        MODE_SSD = 1'b1
    } mode_e;

    localparam int RES_W = 32;
    localparam logic [RES_W-1:0] RES_MAX = '1;

    // Returns {overflow, sum}; the sum clamps at RES_MAX instead of wrapping.
    function automatic logic [RES_W:0] sat_add(input logic [RES_W-1:0] acc,
                                               input logic [63:0]      inc);
        logic [64:0] s;
        s = 65'(acc) + 65'(inc);
        if (s > 65'(RES_MAX)) begin
            sat_add = {1'b1, RES_MAX};
        end else begin
            sat_add = {1'b0, s[RES_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/sad_lanes_if.sv
// Beat/control bundle between a sample source and sad_lanes.
interface sad_lanes_if #(
    parameter int DW    = 8,
    parameter int LANES = 4
);
    import sad_pkg::*;

    // vld_i qualifies dta_i/dtb_i. A beat is taken on every RUN cycle with
    // vld_i=1 and abort_i=0; there is no ready, the block always accepts in RUN.
    logic                  enb_i;
    logic                  mode_i;
    logic                  vld_i;
    logic                  abort_i;
    logic [LANES*DW-1:0]   dta_i;
    logic [LANES*DW-1:0]   dtb_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  sat_o;
    logic [RES_W-1:0]      dt_o;
    state_e                state_dbg;

    modport master (
        output enb_i, mode_i, vld_i, abort_i, dta_i, dtb_i,
        input  busy_o, done_o, sat_o, dt_o, state_dbg
    );

    modport slave (
        input  enb_i, mode_i, vld_i, abort_i, dta_i, dtb_i,
        output busy_o, done_o, sat_o, dt_o, state_dbg
    );

endinterface

// File: rtl/sad_lane.sv
// One lane: absolute or squared difference of two unsigned samples.
module sad_lane
    import sad_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  mode_e           mode,
    output logic [2*DW-1:0] d
);

    logic signed [DW:0] diff;
    logic [DW-1:0]      mag;
    logic [2*DW-1:0]    sq;

    always_comb begin
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        // Magnitude of a DW+1-bit signed difference always fits in DW bits.
        mag  = diff[DW] ? DW'(-diff) : diff[DW-1:0];
        sq   = (2*DW)'(mag) * (2*DW)'(mag);
        d    = (mode == MODE_SSD) ? sq : {{DW{1'b0}}, mag};
    end

endmodule

// File: rtl/sad_lanes.sv
// Block SAD/SSD engine: LANES sample pairs per beat, saturating 32-bit result.
module sad_lanes
    import sad_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int NSAMP = 256
) (
    input  logic       clk,
    input  logic       rst_i,
    sad_lanes_if.slave bus
);

    localparam int BEATS = NSAMP / LANES;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam int SUM_W = 2 * DW + $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    state_e            state;
    state_e            state_nx;
    mode_e             mode_q;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  dt;
    logic [CW-1:0]     cnt;
    logic              sat_flag;
    logic              sat;

    logic [2*DW-1:0]   lane_d [LANES];
    logic [SUM_W-1:0]  tree [LANES];
    logic [SUM_W-1:0]  beat_sum;
    logic [RES_W:0]    add;
    logic              beat;
    logic              last_beat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sad_lane #(.DW(DW)) u_lane (
            .a    (bus.dta_i[k*DW +: DW]),
            .b    (bus.dtb_i[k*DW +: DW]),
            .mode (mode_q),
            .d    (lane_d[k])
        );
    end

    // In-place pairwise reduction: each pass halves the live width, giving a
    // log2(LANES)-deep combinational tree with no register in between.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            tree[k] = SUM_W'(lane_d[k]);
        end
        for (int w = LANES / 2; w >= 1; w = w / 2) begin
            for (int k = 0; k < w; k++) begin
                tree[k] = tree[2*k] + tree[2*k+1];
            end
        end
        beat_sum = tree[0];
    end

    // Abort outranks vld_i, so a beat arriving with abort_i is never counted.
    assign beat      = (state == RUN) && bus.vld_i && !bus.abort_i;
    assign last_beat = beat && (cnt == LAST);
    assign add       = sat_add(acc, 64'(beat_sum));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.enb_i) state_nx = RUN;
            RUN: begin
                if (bus.abort_i)    state_nx = IDLE;
                else if (last_beat) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            mode_q   <= MODE_SAD;
            acc      <= '0;
            cnt      <= '0;
            sat_flag <= 1'b0;
            dt       <= '0;
            sat      <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.enb_i) begin
                acc      <= '0;
                cnt      <= '0;
                sat_flag <= 1'b0;
                mode_q   <= mode_e'(bus.mode_i);
            end
            if (beat) begin
                acc      <= add[RES_W-1:0];
                cnt      <= cnt + 1'b1;
                sat_flag <= sat_flag | add[RES_W];
            end
            // Result lands together with the move to DONE, so it is valid
            // in the same cycle that done_o is high.
            if (last_beat) begin
                dt  <= add[RES_W-1:0];
                sat <= sat_flag | add[RES_W];
            end
        end
    end

    assign bus.busy_o    = (state == RUN);
    assign bus.done_o    = (state == DONE);
    assign bus.dt_o      = dt;
    assign bus.sat_o     = sat;
    assign bus.state_dbg = state;

endmodule
